// File: rtl/qrd_pkg.sv
// Shared constants and state encoding for the QRD output deskewer.
// Elements are Q3.10 signed; the core emits 11 skewed lane beats per frame.
package qrd_pkg;

    localparam int DATA_W  = 14;
    localparam int N       = 4;
    localparam int ONE_Q10 = 1024;
    localparam int T_LAST  = 10;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_e;

endpackage

// File: rtl/qrd_mat_buf.sv
// Frame buffer holding R and Q^H (2 x N x N complex).
// Writes undo the systolic skew; reads return one whole aligned row.
module qrd_mat_buf #(
    parameter int DATA_W = 14,
    parameter int N      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_i,
    input  logic [3:0]          wr_t_i,
    input  logic [N*DATA_W-1:0] lane_r_i,
    input  logic [N*DATA_W-1:0] lane_im_i,
    input  logic [2:0]          rd_b_i,
    output logic [N*DATA_W-1:0] row_r_o,
    output logic [N*DATA_W-1:0] row_im_o
);

    logic [DATA_W-1:0] mem_re_q [2][N][N];
    logic [DATA_W-1:0] mem_im_q [2][N][N];

    logic [3:0]   lane_off [N];
    logic [N-1:0] lane_we;

    // Offset t-i wraps to >= 13 when t < i, so one upper bound rejects both ends;
    // bit 2 of the offset picks Q^H, the low two bits pick the column.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lane_off[i] = wr_t_i - 4'(i);
            lane_we[i]  = wr_en_i && (lane_off[i] <= 4'd7);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        mem_re_q[m][i][j] <= '0;
                        mem_im_q[m][i][j] <= '0;
                    end
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (lane_we[i]) begin
                    mem_re_q[lane_off[i][2]][i][lane_off[i][1:0]] <= lane_r_i[i*DATA_W +: DATA_W];
                    mem_im_q[lane_off[i][2]][i][lane_off[i][1:0]] <= lane_im_i[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            row_r_o[j*DATA_W +: DATA_W]  = mem_re_q[rd_b_i[2]][rd_b_i[1:0]][j];
            row_im_o[j*DATA_W +: DATA_W] = mem_im_q[rd_b_i[2]][rd_b_i[1:0]][j];
        end
    end

endmodule

// File: rtl/qrd_out_deskew.sv
// Captures one skewed QRD output frame, then drains R and Q^H as 8 aligned
// row beats on a valid/ready stream. Input is refused while draining.
module qrd_out_deskew #(
    parameter int DATA_W = qrd_pkg::DATA_W,
    parameter int N      = qrd_pkg::N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [N*DATA_W-1:0] s_lane_r,
    input  logic [N*DATA_W-1:0] s_lane_i,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [N*DATA_W-1:0] m_row_r,
    output logic [N*DATA_W-1:0] m_row_i,
    output logic [1:0]          m_row_idx,
    output logic                m_is_qh,
    output logic                m_last
);

    import qrd_pkg::*;

    state_e              state_q, state_d;
    logic [3:0]          t_q, t_d;
    logic [2:0]          b_q, b_d;
    logic                s_ready_q, s_ready_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic                m_is_qh_q, m_is_qh_d;
    logic [1:0]          m_row_idx_q, m_row_idx_d;
    logic [N*DATA_W-1:0] m_row_r_q, m_row_r_d;
    logic [N*DATA_W-1:0] m_row_i_q, m_row_i_d;

    logic                wr_en;
    logic                load_beat;
    logic [2:0]          rd_b;
    logic [N*DATA_W-1:0] rd_row_r, rd_row_i;

    assign wr_en = s_valid && s_ready_q;

    qrd_mat_buf #(
        .DATA_W (DATA_W),
        .N      (N)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_t_i    (t_q),
        .lane_r_i  (s_lane_r),
        .lane_im_i (s_lane_i),
        .rd_b_i    (rd_b),
        .row_r_o   (rd_row_r),
        .row_im_o  (rd_row_i)
    );

    // The read port always looks one beat ahead so the next row can be loaded
    // into the output registers on the same edge the current one is accepted.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        b_d         = b_q;
        s_ready_d   = s_ready_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_is_qh_d   = m_is_qh_q;
        m_row_idx_d = m_row_idx_q;
        m_row_r_d   = m_row_r_q;
        m_row_i_d   = m_row_i_q;
        rd_b        = b_q + 3'd1;
        load_beat   = 1'b0;

        unique case (state_q)
            IDLE: begin
                s_ready_d = 1'b1;
                if (wr_en) begin
                    state_d = COLLECT;
                    t_d     = 4'd1;
                end
            end
            COLLECT: begin
                if (wr_en) begin
                    if (t_q == 4'(T_LAST)) begin
                        state_d   = DRAIN;
                        s_ready_d = 1'b0;
                        t_d       = 4'd0;
                        b_d       = 3'd0;
                        rd_b      = 3'd0;
                        load_beat = 1'b1;
                    end else begin
                        t_d = t_q + 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    if (b_q == 3'd7) begin
                        state_d   = IDLE;
                        s_ready_d = 1'b1;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                    end else begin
                        b_d       = rd_b;
                        load_beat = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_beat) begin
            m_valid_d   = 1'b1;
            m_row_r_d   = rd_row_r;
            m_row_i_d   = rd_row_i;
            m_row_idx_d = rd_b[1:0];
            m_is_qh_d   = rd_b[2];
            m_last_d    = (rd_b == 3'd7);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            t_q         <= '0;
            b_q         <= '0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_is_qh_q   <= 1'b0;
            m_row_idx_q <= '0;
            m_row_r_q   <= '0;
            m_row_i_q   <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            b_q         <= b_d;
            s_ready_q   <= s_ready_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_is_qh_q   <= m_is_qh_d;
            m_row_idx_q <= m_row_idx_d;
            m_row_r_q   <= m_row_r_d;
            m_row_i_q   <= m_row_i_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign m_is_qh   = m_is_qh_q;
    assign m_row_idx = m_row_idx_q;
    assign m_row_r   = m_row_r_q;
    assign m_row_i   = m_row_i_q;

endmodule

// File: tb/tb_qrd_out_deskew.sv
// Scoreboard bench for qrd_out_deskew: the driver pushes the expected row beats
// of each frame, a negedge monitor pops and compares them as the DUT drains.
module tb_qrd_out_deskew;

    import qrd_pkg::*;

    localparam int W = DATA_W;

    typedef struct {
        logic [N*W-1:0] rowR;
        logic [N*W-1:0] rowI;
        logic [1:0]     idx;
        logic           isQh;
        logic           last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           sValid = 1'b0;
    logic           mReady = 1'b1;
    logic [N*W-1:0] sLaneR = '0;
    logic [N*W-1:0] sLaneI = '0;

    logic           s_ready;
    logic           m_valid;
    logic [N*W-1:0] m_row_r;
    logic [N*W-1:0] m_row_i;
    logic [1:0]     m_row_idx;
    logic           m_is_qh;
    logic           m_last;

    beat_t          expQ[$];
    beat_t          monE;
    logic [W-1:0]   frameR [N][11];
    logic [W-1:0]   frameI [N][11];

    int             nVec = 0;
    int             nMis = 0;
    int             validCycles = 0;
    bit             bpMode = 1'b0;
    bit             lastAccepted = 1'b0;

    qrd_out_deskew dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (sValid),
        .s_ready   (s_ready),
        .s_lane_r  (sLaneR),
        .s_lane_i  (sLaneI),
        .m_valid   (m_valid),
        .m_ready   (mReady),
        .m_row_r   (m_row_r),
        .m_row_i   (m_row_i),
        .m_row_idx (m_row_idx),
        .m_is_qh   (m_is_qh),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Tagged frame: lane i at beat t carries r = base + 100*i + t, im = -r.
    task automatic setTagFrame(input int base);
        for (int i = 0; i < N; i++) begin
            for (int t = 0; t < 11; t++) begin
                frameR[i][t] = W'(base + 100*i + t);
                frameI[i][t] = W'(-(base + 100*i + t));
            end
        end
    endtask

    // Full-scale R entries and an identity Q^H; beats outside the capture map carry junk.
    task automatic setExtremeFrame();
        for (int i = 0; i < N; i++) begin
            for (int t = 0; t < 11; t++) begin
                frameR[i][t] = W'(4660);
                frameI[i][t] = W'(-4660);
                if (t >= i && t <= i + 3) begin
                    frameR[i][t] = W'((((t - i) % 2) == 0) ? -8192 : 8191);
                    frameI[i][t] = W'((((t - i) % 2) == 0) ? 8191 : -8192);
                end else if (t >= i + 4 && t <= i + 7) begin
                    frameR[i][t] = W'((t - i - 4 == i) ? ONE_Q10 : 0);
                    frameI[i][t] = W'(0);
                end
            end
        end
    endtask

    task automatic pushExpected();
        beat_t e;
        for (int k = 0; k < 8; k++) begin
            int row;
            int off;
            row = k % 4;
            off = (k >= 4) ? 4 : 0;
            for (int j = 0; j < N; j++) begin
                e.rowR[j*W +: W] = frameR[row][row + j + off];
                e.rowI[j*W +: W] = frameI[row][row + j + off];
            end
            e.idx  = 2'(row);
            e.isQh = (k >= 4);
            e.last = (k == 7);
            expQ.push_back(e);
        end
    endtask

    // Drives the 11 lane beats of the current frame; junk while s_ready is low.
    task automatic applyStimulus(input int gapAfter, input int abortAt, input bit holdValid);
        int  t;
        int  cyc;
        int  gapLeft;
        bit  acc;
        t = 0;
        cyc = 0;
        gapLeft = 0;
        if (abortAt < 0) pushExpected();
        while (t < 11 && cyc < 300) begin
            if (gapLeft > 0) begin
                sValid = 1'b0;
                sLaneR = (N*W)'({$urandom, $urandom});
                sLaneI = (N*W)'({$urandom, $urandom});
                gapLeft--;
            end else if (!s_ready) begin
                sValid = holdValid;
                sLaneR = (N*W)'({$urandom, $urandom});
                sLaneI = (N*W)'({$urandom, $urandom});
            end else begin
                sValid = 1'b1;
                for (int i = 0; i < N; i++) begin
                    sLaneR[i*W +: W] = frameR[i][t];
                    sLaneI[i*W +: W] = frameI[i][t];
                end
            end
            @(negedge clk);
            acc = sValid && s_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                t++;
                if (t == gapAfter + 1) gapLeft = 3;
                if (t == abortAt) begin
                    rst = 1'b1;
                    #1;
                    checkOutput("abortMValid", 64'(m_valid), 64'(0));
                    checkOutput("abortSReady", 64'(s_ready), 64'(0));
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    sValid = 1'b0;
                    @(negedge clk);
                    checkOutput("abortSReadyHeld", 64'(s_ready), 64'(0));
                    @(posedge clk);
                    #1;
                    checkOutput("abortSReadyRise", 64'(s_ready), 64'(1));
                    return;
                end
            end
        end
        if (t < 11) begin
            nVec++;
            nMis++;
            $display("[TB] FAIL frameTimeout: accepted %0d beats, expected 11", t);
        end
        if (!holdValid) sValid = 1'b0;
    endtask

    task automatic waitDrain();
        int c;
        c = 0;
        while (expQ.size() > 0 && c < 300) begin
            @(posedge clk);
            c++;
        end
        if (expQ.size() > 0) begin
            nVec++;
            nMis++;
            $display("[TB] FAIL drainTimeout: %0d beats outstanding, expected 0", expQ.size());
            expQ.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // m_ready is 1 normally; in backpressure mode it alternates starting with 1
    // on the first valid cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!bpMode) mReady = 1'b1;
            else if (!m_valid) mReady = 1'b0;
            else mReady = ~mReady;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            lastAccepted = 1'b0;
        end else begin
            if (lastAccepted) begin
                checkOutput("sReadyAfterDrain", 64'(s_ready), 64'(1));
                checkOutput("mValidAfterDrain", 64'(m_valid), 64'(0));
                lastAccepted = 1'b0;
            end
            if (m_valid) begin
                validCycles++;
                checkOutput("sReadyWhileDrain", 64'(s_ready), 64'(0));
                if (expQ.size() == 0) begin
                    nVec++;
                    nMis++;
                    $display("[TB] FAIL unexpectedBeat: got row %0d qh %0d, expected no beat", m_row_idx, m_is_qh);
                end else begin
                    monE = expQ[0];
                    checkOutput("rowR", 64'(m_row_r), 64'(monE.rowR));
                    checkOutput("rowI", 64'(m_row_i), 64'(monE.rowI));
                    checkOutput("rowIdx", 64'(m_row_idx), 64'(monE.idx));
                    checkOutput("isQh", 64'(m_is_qh), 64'(monE.isQh));
                    checkOutput("last", 64'(m_last), 64'(monE.last));
                    if (mReady) begin
                        void'(expQ.pop_front());
                        if (monE.last) lastAccepted = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        #2;
        checkOutput("resetMValid", 64'(m_valid), 64'(0));
        checkOutput("resetSReady", 64'(s_ready), 64'(0));
        checkOutput("resetMLast", 64'(m_last), 64'(0));
        checkOutput("resetRowR", 64'(m_row_r), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("sReadyBeforeEdge", 64'(s_ready), 64'(0));
        @(posedge clk);
        #1;
        checkOutput("sReadyRise", 64'(s_ready), 64'(1));

        $display("[TB] test 1: tagged frame");
        validCycles = 0;
        setTagFrame(0);
        applyStimulus(-1, -1, 1'b0);
        waitDrain();
        checkOutput("t1ValidCycles", 64'(validCycles), 64'(8));

        $display("[TB] test 2: backpressure");
        validCycles = 0;
        bpMode = 1'b1;
        setTagFrame(0);
        applyStimulus(-1, -1, 1'b0);
        waitDrain();
        bpMode = 1'b0;
        checkOutput("t2ValidCycles", 64'(validCycles), 64'(15));

        $display("[TB] test 3: input gaps");
        setTagFrame(0);
        applyStimulus(5, -1, 1'b0);
        waitDrain();

        $display("[TB] test 4: back-to-back frames");
        setTagFrame(0);
        applyStimulus(-1, -1, 1'b1);
        setTagFrame(1000);
        applyStimulus(-1, -1, 1'b1);
        sValid = 1'b0;
        waitDrain();

        $display("[TB] test 5: reset mid-collect");
        setTagFrame(2000);
        applyStimulus(-1, 6, 1'b0);
        setTagFrame(3000);
        applyStimulus(-1, -1, 1'b0);
        waitDrain();

        $display("[TB] test 6: extremes");
        setExtremeFrame();
        applyStimulus(-1, -1, 1'b0);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
